// File: rtl/alu_ctrl_id_ex.sv
// ALU-control slice of the ID/EX pipeline register: decodes the ID instruction into
// ALUOp/sign/operand selects/extended immediate and registers them with stall and flush.
module alu_ctrl_id_ex #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [4:0]       ex_alu_op,
  output logic             ex_sign,
  output logic [1:0]       ex_src1,
  output logic             ex_src2,
  output logic [31:0]      ex_imm,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;

  logic [5:0]       opcode, funct;
  logic [4:0]       alu_op_d, alu_op_q;
  logic             sign_d, sign_q;
  logic [1:0]       src1_d, src1_q;
  logic             src2_d, src2_q;
  logic             zext;
  logic [31:0]      imm_d, imm_q;
  logic             ill_d, ill_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_instr_bits;

  assign opcode            = id_instr[31:26];
  assign funct             = id_instr[5:0];
  // Register fields are not needed by ALU control; only opcode, funct and imm16 are.
  assign unused_instr_bits = ^id_instr[25:16];

  always_comb begin
    alu_op_d = ALU_AND;
    sign_d   = 1'b0;
    src1_d   = 2'b00;
    src2_d   = 1'b0;
    zext     = 1'b0;
    ill_d    = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin alu_op_d = ALU_ADD; sign_d = 1'b1; end
          6'h21: alu_op_d = ALU_ADD;
          6'h22: begin alu_op_d = ALU_SUB; sign_d = 1'b1; end
          6'h23: alu_op_d = ALU_SUB;
          6'h24: alu_op_d = ALU_AND;
          6'h25: alu_op_d = ALU_OR;
          6'h26: alu_op_d = ALU_XOR;
          6'h27: alu_op_d = ALU_NOR;
          6'h2A: begin alu_op_d = ALU_SLT; sign_d = 1'b1; end
          6'h2B: alu_op_d = ALU_SLT;
          6'h00: begin alu_op_d = ALU_SLL; src1_d = 2'b01; end
          6'h02: begin alu_op_d = ALU_SRL; src1_d = 2'b01; end
          6'h03: begin alu_op_d = ALU_SRA; src1_d = 2'b01; end
          6'h04: alu_op_d = ALU_SLL;
          6'h06: alu_op_d = ALU_SRL;
          6'h07: alu_op_d = ALU_SRA;
          6'h08, 6'h09: alu_op_d = ALU_ADD;
          default: ill_d = 1'b1;
        endcase
      end
      6'h08: begin alu_op_d = ALU_ADD; sign_d = 1'b1; src2_d = 1'b1; end
      6'h09: begin alu_op_d = ALU_ADD; src2_d = 1'b1; end
      6'h0A: begin alu_op_d = ALU_SLT; sign_d = 1'b1; src2_d = 1'b1; end
      6'h0B: begin alu_op_d = ALU_SLT; src2_d = 1'b1; end
      6'h0C: begin alu_op_d = ALU_AND; src2_d = 1'b1; zext = 1'b1; end
      6'h0D: begin alu_op_d = ALU_OR;  src2_d = 1'b1; zext = 1'b1; end
      6'h0E: begin alu_op_d = ALU_XOR; src2_d = 1'b1; zext = 1'b1; end
      // lui is realised as imm << 16, with the shift amount supplied as constant 16.
      6'h0F: begin alu_op_d = ALU_SLL; src1_d = 2'b10; src2_d = 1'b1; zext = 1'b1; end
      6'h23, 6'h2B: begin alu_op_d = ALU_ADD; src2_d = 1'b1; end
      6'h04, 6'h05: alu_op_d = ALU_SUB;
      6'h02, 6'h03: alu_op_d = ALU_AND;
      default: ill_d = 1'b1;
    endcase
    imm_d = zext ? {16'h0000, id_instr[15:0]} : {{16{id_instr[15]}}, id_instr[15:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      alu_op_q <= ALU_AND;
      sign_q   <= 1'b0;
      src1_q   <= 2'b00;
      src2_q   <= 1'b0;
      imm_q    <= '0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      alu_op_q <= ALU_AND;
      sign_q   <= 1'b0;
      src1_q   <= 2'b00;
      src2_q   <= 1'b0;
      imm_q    <= '0;
      ill_q    <= 1'b0;
    end else if (!stall) begin
      valid_q  <= id_valid;
      alu_op_q <= alu_op_d;
      sign_q   <= sign_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      imm_q    <= imm_d;
      ill_q    <= id_valid & ill_d;
      if (id_valid && ill_d && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid    = valid_q;
  assign ex_alu_op   = alu_op_q;
  assign ex_sign     = sign_q;
  assign ex_src1     = src1_q;
  assign ex_src2     = src2_q;
  assign ex_imm      = imm_q;
  assign ex_illegal  = ill_q;
  assign illegal_cnt = cnt_q;

endmodule
